// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci stream checker.
package fib_pkg;

  localparam int FIB_WIDTH    = 8;
  localparam int FIB_LAST_IDX = 13;

  // HUNT: waiting for a sequence start. LOCK: tracking the reference term by term.
  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  // A sequence always starts at term 0.
  function automatic logic is_start(input logic [FIB_WIDTH-1:0] value);
    return (value == '0);
  endfunction

endpackage

// File: rtl/fibonacci_checker_if.sv
// Received Fibonacci stream.
// Handshake: one sample transfers on every rising clk edge where in_valid is 1.
// There is no ready signal because the checker never applies backpressure.
interface fibonacci_checker_if #(
  parameter int WIDTH = fib_pkg::FIB_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] in_number;

  modport master (output in_valid, output in_number);
  modport slave  (input  in_valid, input  in_number);

endinterface

// File: rtl/fib_ref_gen.sv
// Reference term generator: holds the (a, b) pair of consecutive Fibonacci
// terms. expected is always a. clear and advance together restart the
// sequence and step it once, so expected becomes 1.
module fib_ref_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             clear,
  output logic [WIDTH-1:0] expected
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Update the term pair. Sums wrap modulo 2^WIDTH; the wrap at the last
  // term does not matter because the sequence is cleared there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= WIDTH'(1);
    end else if (clear && advance) begin
      a_q <= WIDTH'(1);
      b_q <= WIDTH'(1);
    end else if (clear) begin
      a_q <= '0;
      b_q <= WIDTH'(1);
    end else if (advance) begin
      a_q <= b_q;
      b_q <= a_q + b_q;
    end
  end

  assign expected = a_q;

endmodule

// File: rtl/fibonacci_checker.sv
// In-system checker for the Fibonacci stream. It locks on a term-0 sample,
// compares each following valid sample with the regenerated reference,
// counts mismatches and completed sequences, and re-locks after errors.
// IDX_W must satisfy 2^IDX_W > LAST_IDX.
module fibonacci_checker
  import fib_pkg::*;
#(
  parameter int WIDTH    = FIB_WIDTH,
  parameter int LAST_IDX = FIB_LAST_IDX,
  parameter int CNT_W    = 8,
  parameter int IDX_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  fibonacci_checker_if.slave s_in,
  input  logic               seq_restart,
  output logic [WIDTH-1:0]   expected,
  output logic [IDX_W-1:0]   term_idx,
  output logic               locked,
  output logic               err_pulse,
  output logic               wrap_pulse,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   seq_count,
  output state_e             state_dbg
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] seq_count_q, seq_count_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             ref_advance;
  logic             ref_clear;
  logic             start_sample;
  logic             match;
  logic             at_last;

  fib_ref_gen #(
    .WIDTH (WIDTH)
  ) u_ref_gen (
    .clk      (clk),
    .reset    (reset),
    .advance  (ref_advance),
    .clear    (ref_clear),
    .expected (expected)
  );

  assign start_sample = is_start(FIB_WIDTH'(s_in.in_number));
  assign match        = (s_in.in_number == expected);
  assign at_last      = (idx_q == IDX_W'(LAST_IDX));

  // Register FSM state, term index, counters and pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= HUNT;
      idx_q        <= '0;
      err_count_q  <= '0;
      seq_count_q  <= '0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      err_count_q  <= err_count_d;
      seq_count_q  <= seq_count_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  // Next-state logic: restart wins over the sample; mismatches on a 0
  // are treated as a fresh start, other mismatches drop back to HUNT.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    err_count_d  = err_count_q;
    seq_count_d  = seq_count_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    ref_advance  = 1'b0;
    ref_clear    = 1'b0;

    if (seq_restart) begin
      state_d   = HUNT;
      idx_d     = '0;
      ref_clear = 1'b1;
    end else if (s_in.in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (start_sample) begin
            state_d     = LOCK;
            idx_d       = IDX_W'(1);
            ref_advance = 1'b1;
          end
        end
        LOCK: begin
          if (match) begin
            if (at_last) begin
              idx_d        = '0;
              ref_clear    = 1'b1;
              wrap_pulse_d = 1'b1;
              if (seq_count_q != '1) seq_count_d = seq_count_q + 1'b1;
            end else begin
              idx_d       = idx_q + 1'b1;
              ref_advance = 1'b1;
            end
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            ref_clear = 1'b1;
            if (start_sample) begin
              idx_d       = IDX_W'(1);
              ref_advance = 1'b1;
            end else begin
              state_d = HUNT;
              idx_d   = '0;
            end
          end
        end
        default: begin
          state_d   = HUNT;
          idx_d     = '0;
          ref_clear = 1'b1;
        end
      endcase
    end
  end

  assign term_idx   = idx_q;
  assign locked     = (state_q == LOCK);
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_count  = err_count_q;
  assign seq_count  = seq_count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Self-checking bench for fibonacci_checker: a reference model built on a
// table of Fibonacci terms feeds an expected-output queue.
module tb_fibonacci_checker;
  import fib_pkg::*;

  localparam int W = 31;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic seq_restart = 1'b0;
  always #5 clk = ~clk;

  fibonacci_checker_if #(.WIDTH(8)) s_if ();

  logic [7:0] expected;
  logic [3:0] term_idx;
  logic       locked, err_pulse, wrap_pulse;
  logic [7:0] err_count, seq_count;
  state_e     state_dbg;

  fibonacci_checker dut (
    .clk         (clk),
    .reset       (reset),
    .s_in        (s_if.slave),
    .seq_restart (seq_restart),
    .expected    (expected),
    .term_idx    (term_idx),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .wrap_pulse  (wrap_pulse),
    .err_count   (err_count),
    .seq_count   (seq_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- model + scoreboard ----------------
  logic [7:0] fib_tab [14] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8,
                               8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};
  logic       m_locked, m_err, m_wrap;
  int         m_idx;
  logic [7:0] m_errc, m_seqc;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] dut_word();
    return {expected, term_idx, locked, err_pulse, wrap_pulse, err_count, seq_count};
  endfunction

  function automatic logic [W-1:0] model_word();
    return {fib_tab[m_idx], 4'(m_idx), m_locked, m_err, m_wrap, m_errc, m_seqc};
  endfunction

  task automatic model_reset();
    m_locked = 1'b0; m_err = 1'b0; m_wrap = 1'b0;
    m_idx = 0; m_errc = 8'd0; m_seqc = 8'd0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] n, input logic rs);
    m_err = 1'b0;
    m_wrap = 1'b0;
    if (rs) begin
      m_locked = 1'b0;
      m_idx = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (n == 8'd0) begin
          m_locked = 1'b1;
          m_idx = 1;
        end
      end else if (n == fib_tab[m_idx]) begin
        if (m_idx == 13) begin
          m_idx = 0;
          m_wrap = 1'b1;
          if (m_seqc != 8'hFF) m_seqc++;
        end else begin
          m_idx++;
        end
      end else begin
        m_err = 1'b1;
        if (m_errc != 8'hFF) m_errc++;
        if (n == 8'd0) m_idx = 1;
        else begin
          m_locked = 1'b0;
          m_idx = 0;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic v, input logic [7:0] n, input logic rs, input string tag);
    logic [W-1:0] act, ex;
    @(negedge clk);
    s_if.in_valid = v;
    s_if.in_number = n;
    seq_restart = rs;
    model_step(v, n, rs);
    exp_q.push_back(model_word());
    @(posedge clk);
    #1;
    act = dut_word();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, actual=%h", tag, act);
    end else begin
      ex = exp_q.pop_front();
      if (act !== ex) begin
        errors++;
        $display("FAIL %s: actual={exp,idx,lk,ep,wp,ec,sc}=%h required=%h (n=%0d v=%0b rs=%0b)",
                 tag, act, ex, n, v, rs);
      end
    end
    s_if.in_valid = 1'b0;
    seq_restart = 1'b0;
  endtask

  task automatic drive_seq(input string tag);
    for (int i = 0; i < 14; i++) drive_cycle(1'b1, fib_tab[i], 1'b0, tag);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    s_if.in_valid = 1'b0;
    s_if.in_number = 8'd0;
    model_reset();
    #2;
    checks++;
    if (dut_word() !== '0 || state_dbg !== HUNT) begin
      errors++;
      $display("FAIL reset_values: actual=%h state=%0d required=0 state=HUNT", dut_word(), state_dbg);
    end
    @(negedge clk);
    reset = 1'b1;
    drive_cycle(1'b0, 8'd0, 1'b0, "reset_idle");
  endtask

  task automatic test_single_sequence();
    drive_seq("single_seq");
    checks++;
    if (seq_count !== 8'd1 || expected !== 8'd0 || term_idx !== 4'd0) begin
      errors++;
      $display("FAIL single_seq_end: actual sc=%0d exp=%0d idx=%0d required 1,0,0",
               seq_count, expected, term_idx);
    end
  endtask

  task automatic test_back_to_back();
    drive_cycle(1'b0, 8'd0, 1'b1, "b2b_restart");
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 14; i++) begin
        drive_cycle(1'b1, fib_tab[i], 1'b0, "b2b_sample");
        for (int g = $urandom_range(1, 3); g > 0; g--)
          drive_cycle(1'b0, 8'($urandom_range(0, 255)), 1'b0, "b2b_gap");
      end
    end
    checks++;
    if (seq_count !== 8'd3 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL b2b_counts: actual sc=%0d ec=%0d required 3,0", seq_count, err_count);
    end
  endtask

  task automatic test_error_relock();
    logic [7:0] pat [9] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd4, 8'd7, 8'd9, 8'd0, 8'd1};
    drive_cycle(1'b0, 8'd0, 1'b1, "err_restart");
    for (int i = 0; i < 9; i++) drive_cycle(1'b1, pat[i], 1'b0, "err_relock");
    checks++;
    if (locked !== 1'b1 || expected !== 8'd1 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL err_relock_end: actual lk=%0b exp=%0d ec=%0d required 1,1,1",
               locked, expected, err_count);
    end
  endtask

  task automatic test_midstream_restart();
    logic [7:0] pat [8] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd1};
    drive_cycle(1'b0, 8'd0, 1'b1, "mid_restart");
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, pat[i], 1'b0, "mid_stream");
    checks++;
    if (expected !== 8'd2 || err_count !== 8'd2) begin
      errors++;
      $display("FAIL mid_stream_end: actual exp=%0d ec=%0d required 2,2", expected, err_count);
    end
  endtask

  task automatic test_seq_restart();
    drive_cycle(1'b0, 8'd0, 1'b1, "sr_restart");
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, fib_tab[i], 1'b0, "sr_lock");
    drive_cycle(1'b1, 8'd5, 1'b1, "sr_with_valid");
    checks++;
    if (err_pulse !== 1'b0 || locked !== 1'b0 || term_idx !== 4'd0 || err_count !== m_errc) begin
      errors++;
      $display("FAIL sr_effect: actual ep=%0b lk=%0b idx=%0d ec=%0d required 0,0,0,%0d",
               err_pulse, locked, term_idx, err_count, m_errc);
    end
  endtask

  task automatic test_saturation();
    drive_cycle(1'b0, 8'd0, 1'b1, "sat_restart");
    drive_cycle(1'b1, 8'd0, 1'b0, "sat_lock");
    for (int i = 0; i < 300; i++) drive_cycle(1'b1, 8'd0, 1'b0, "sat_mismatch");
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_err_count: actual=%0d required=255", err_count);
    end
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, fib_tab[i + 1], 1'b0, "sat_midseq");
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_word() !== '0 || state_dbg !== HUNT) begin
      errors++;
      $display("FAIL async_reset: actual=%h state=%0d required=0 state=HUNT", dut_word(), state_dbg);
    end
    @(negedge clk);
    reset = 1'b1;
    drive_cycle(1'b1, 8'd3, 1'b0, "post_reset_ignore");
    drive_cycle(1'b1, 8'd0, 1'b0, "post_reset_lock");
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_sequence();
    test_back_to_back();
    test_error_relock();
    test_midstream_restart();
    test_seq_restart();
    test_saturation();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d entries required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
